// File: rtl/ntt_pkg.sv
// Shared constants, FSM encoding and address helpers for the forward Kyber NTT sequencer.
package ntt_pkg;

  localparam int Q          = 3329;
  localparam int NTT_LOGN   = 8;
  localparam int NLAYERS    = NTT_LOGN - 1;
  localparam int NTT_RD_LAT = 1;
  localparam int NTT_BF_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Butterfly b of layer l touches addr_a and addr_a + 2**(logn-1-l).
  function automatic int bf_addr_a(input int logn, input int l, input int b);
    int sh;
    sh = logn - 1 - l;
    return ((b >> sh) << (sh + 1)) | (b & ((1 << sh) - 1));
  endfunction

  function automatic int bf_zeta(input int logn, input int l, input int b);
    return (1 << l) + (b >> (logn - 1 - l));
  endfunction

endpackage

// File: rtl/ntt_addr_delay.sv
// Resettable shift register; carries write-back tags alongside the RAM and butterfly pipelines.
module ntt_addr_delay #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             srst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d;

    if (gi == 0) begin : g_in
      assign d = din;
    end else begin : g_link
      assign d = g_stage[gi-1].q_reg;
    end

    always_ff @(posedge clk) begin
      if (srst) begin
        q_reg <= '0;
      end else begin
        q_reg <= d;
      end
    end
  end

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/ntt_layer_scheduler.sv
// Address/control sequencer for one forward Kyber NTT: one butterfly per cycle, pipeline
// drained between layers so no coefficient is read before its previous-layer write-back.
module ntt_layer_scheduler
  import ntt_pkg::*;
#(
  parameter int LOGN   = NTT_LOGN,
  parameter int RD_LAT = NTT_RD_LAT,
  parameter int BF_LAT = NTT_BF_LAT
) (
  input  logic            clk,
  input  logic            r,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic            bf_valid,
  output logic [LOGN-2:0] zeta_idx,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int NL        = LOGN - 1;
  localparam int NB        = 2 ** (LOGN - 1);
  localparam int DRAIN_LEN = RD_LAT + BF_LAT;
  localparam int LW        = $clog2(NL + 1);
  localparam int BW        = LOGN - 1;
  localparam int DW        = $clog2(DRAIN_LEN + 1);
  localparam int TAG_W     = 1 + 2 * LOGN;
  localparam int ZT_W      = LOGN;

  state_e          state_reg, state_next;
  logic [LW-1:0]   l_reg, l_next;
  logic [BW-1:0]   b_reg, b_next;
  logic [DW-1:0]   drain_reg, drain_next;
  logic            issue_next, flush_next;
  int              a_int, len_int, z_int;
  logic [LOGN-1:0] addr_a_next, addr_b_next;
  logic [LOGN-2:0] zeta_next;

  logic            rd_en_reg, busy_reg, done_reg, flush_reg;
  logic [LOGN-1:0] rd_addr_a_reg, rd_addr_b_reg;
  logic [LOGN-2:0] zeta_rd_reg;
  logic [TAG_W-1:0] tag_out;
  logic [ZT_W-1:0]  zeta_out;

  always_comb begin
    state_next = state_reg;
    l_next     = l_reg;
    b_next     = b_reg;
    drain_next = drain_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_READ;
          l_next     = '0;
          b_next     = '0;
        end
      end
      ST_READ: begin
        if (b_reg == BW'(NB - 1)) begin
          state_next = ST_DRAIN;
          drain_next = '0;
        end else begin
          b_next = b_reg + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_reg == DW'(DRAIN_LEN - 1)) begin
          if (l_reg == LW'(NL - 1)) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_READ;
            l_next     = l_reg + 1'b1;
            b_next     = '0;
          end
        end else begin
          drain_next = drain_reg + 1'b1;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // The butterfly only advances on valid_in, so keep it clocked after the last real beat.
  always_comb begin
    issue_next = (state_next == ST_READ);
    flush_next = (state_next == ST_DRAIN) &&
                 (drain_next >= DW'(RD_LAT)) &&
                 (drain_next <= DW'(RD_LAT + BF_LAT - 2));
    len_int     = 1 << (LOGN - 1 - int'(l_next));
    a_int       = bf_addr_a(LOGN, int'(l_next), int'(b_next));
    z_int       = bf_zeta(LOGN, int'(l_next), int'(b_next));
    addr_a_next = LOGN'(a_int);
    addr_b_next = LOGN'(a_int + len_int);
    zeta_next   = BW'(z_int);
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_reg     <= ST_IDLE;
      l_reg         <= '0;
      b_reg         <= '0;
      drain_reg     <= '0;
      rd_en_reg     <= 1'b0;
      rd_addr_a_reg <= '0;
      rd_addr_b_reg <= '0;
      zeta_rd_reg   <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      flush_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      l_reg         <= l_next;
      b_reg         <= b_next;
      drain_reg     <= drain_next;
      rd_en_reg     <= issue_next;
      rd_addr_a_reg <= issue_next ? addr_a_next : '0;
      rd_addr_b_reg <= issue_next ? addr_b_next : '0;
      zeta_rd_reg   <= issue_next ? zeta_next : '0;
      busy_reg      <= (state_next == ST_READ) || (state_next == ST_DRAIN);
      done_reg      <= (state_next == ST_DONE);
      flush_reg     <= flush_next;
    end
  end

  ntt_addr_delay #(
    .DEPTH(DRAIN_LEN),
    .WIDTH(TAG_W)
  ) u_tag_delay (
    .clk (clk),
    .srst(r),
    .din ({rd_en_reg, rd_addr_a_reg, rd_addr_b_reg}),
    .dout(tag_out)
  );

  ntt_addr_delay #(
    .DEPTH(RD_LAT),
    .WIDTH(ZT_W)
  ) u_zeta_delay (
    .clk (clk),
    .srst(r),
    .din ({rd_en_reg, zeta_rd_reg}),
    .dout(zeta_out)
  );

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign rd_en     = rd_en_reg;
  assign rd_addr_a = rd_addr_a_reg;
  assign rd_addr_b = rd_addr_b_reg;
  assign bf_valid  = zeta_out[ZT_W-1] | flush_reg;
  assign zeta_idx  = zeta_out[LOGN-2:0];
  assign wr_en     = tag_out[TAG_W-1];
  assign wr_addr_a = tag_out[2*LOGN-1:LOGN];
  assign wr_addr_b = tag_out[LOGN-1:0];

endmodule
